rename_map_stage: RTL and testbench
===================================

# rename_map_stage

Register-rename stage of the out-of-order pipeline. It consumes the architectural source and destination register numbers, with the 5-bit destination already chosen by the decode-stage destination select. It maps them through a register alias table (RAT) and allocates a fresh physical destination tag from a free list. Commit returns retired tags to the free list. Output is one registered pipeline stage feeding dispatch.

## Interface
Parameters:
- PHYS_REGS, 64, number of physical registers; must be a power of two, > 32.
- PTAG_W, $clog2(PHYS_REGS), physical tag width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction present.
- in_ready  out  1  stage accepts this cycle.
- in_rs  in  5  architectural source A.
- in_rt  in  5  architectural source B.
- in_rd  in  5  architectural destination.
- in_rd_we  in  1  instruction writes in_rd.
- out_valid  out  1  renamed instruction present.
- out_ready  in  1  dispatch accepts.
- out_ps  out  PTAG_W  physical tag for rs.
- out_pt  out  PTAG_W  physical tag for rt.
- out_pd  out  PTAG_W  new physical destination; 0 when no write.
- out_old_pd  out  PTAG_W  previous mapping of rd, to be freed at commit.
- out_rd_we  out  1  registered in_rd_we after zero-reg suppression.
- commit_valid  in  1  retire one tag.
- commit_tag  in  PTAG_W  tag returned to free list.
- free_count  out  PTAG_W+1  free-list occupancy.

## Operation
- Reset: RAT[i] = i for i = 0..31. Free list holds tags 32..PHYS_REGS-1 in ascending order, so free_count = PHYS_REGS-32. All out_* = 0; out_valid = 0.
- Accept = in_valid & in_ready.
- in_ready = (~out_valid | out_ready) & (free_count != 0). It is registered-count based and independent of in_rd_we.
- On accept:
  - out_ps = RAT[in_rs] and out_pt = RAT[in_rt], both read before this cycle's RAT write. rd == rs therefore yields the old mapping.
  - If in_rd_we: pop the free-list head into out_pd, set out_old_pd = RAT[in_rd], and write RAT[in_rd] = popped tag.
  - Else: out_pd = 0, out_old_pd = 0, no pop, no RAT write.
- Output register: on accept it loads and out_valid = 1. Otherwise, if out_ready it sets out_valid = 0. Otherwise it holds all outputs stable.
- Free list: circular FIFO of depth PHYS_REGS-32. Head and tail pointers wrap modulo depth.
  - commit_valid pushes commit_tag at the tail.
  - Next free_count = free_count + commit − pop.
  - A simultaneous push and pop are both honoured.
  - A push when free_count == depth is illegal: ignored, plus a simulation assertion.
- Back-to-back accepts: the second instruction sees the RAT update of the first. There is no bypass needed because the RAT write is at the accept edge.

## Timing
- Latency: 1 cycle, from accept edge to out_valid.
- Throughput: 1 instruction per cycle while free_count != 0 and downstream is not stalled.
- Commit into an empty list: in_ready rises the cycle after the commit edge, not the same cycle.
- Reset asserted mid-operation: on that edge everything returns to reset state, regardless of in_valid or commit_valid. In-flight output is discarded.

## Configuration
- RENAME_ZERO_REG_EN
  - Defined: architectural register 0 is hardwired.
    - in_rs/in_rt == 0 always gives tag 0.
    - in_rd == 0 is treated as in_rd_we = 0: no pop, no RAT write, out_rd_we = 0.
  - Undefined: register 0 is renamed like any other.

## Structure
- Package rename_pkg: ARCH_REGS = 32, ARCH_W = 5, typedef arch_reg_t (logic [4:0]). The ptag_t typedef is parameterised via PTAG_W default.
- Sub-module rename_free_list: circular FIFO with push, pop, head tag, and count.
- The RAT and output register live in the top module.

## Test plan
- After reset, rename rd=5, rs=1, rt=2, we=1 -> out_ps=1, out_pt=2, out_pd=32, out_old_pd=5, out_valid next cycle.
- Next cycle, rename rd=6, rs=5, rt=5 -> out_ps=32, out_pt=32, out_pd=33, out_old_pd=6.
- Rename rd=7, rs=7 in one instruction -> out_ps=7 (old mapping), out_pd=next free tag.
- Exhaust the list with 32 renames -> free_count=0 and in_ready=0. Commit tag 5 -> in_ready=1 the following cycle, and the next rename gets out_pd=5.
- Hold out_ready=0 with out_valid=1 -> outputs stable and in_ready=0. Release -> the next accept proceeds.
- With RENAME_ZERO_REG_EN, rd=0, we=1 -> out_pd=0, out_rd_we=0, free_count unchanged. Reset mid-stream -> free_count=32 and RAT[5]=5.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types and sizes for the register-rename stage.
// Provides architectural register count/width and default tag type.
package rename_pkg;
  localparam int ARCH_REGS  = 32;
  localparam int ARCH_W     = 5;
  localparam int PTAG_W_DEF = 6;

  typedef logic [ARCH_W-1:0]     arch_reg_t;
  typedef logic [PTAG_W_DEF-1:0] ptag_t;
endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags, depth PHYS_REGS-32.
// Ports: push_i/push_tag_i (commit), pop_i, head_o (next tag), count_o.
module rename_free_list
  import rename_pkg::*;
#(
  parameter int PHYS_REGS = 64,
  parameter int PTAG_W    = $clog2(PHYS_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [PTAG_W-1:0] push_tag_i,
  input  logic              pop_i,
  output logic [PTAG_W-1:0] head_o,
  output logic [PTAG_W:0]   count_o
);
  localparam int DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PTAG_W + 1;

  logic [PTAG_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full list is dropped.
  assign push_ok = push_i & (count_q != CW'(DEPTH));

  always_comb begin
    head_d  = pop_i ? wrap_inc(head_q) : head_q;
    tail_d  = push_ok ? wrap_inc(tail_q) : tail_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= PTAG_W'(ARCH_REGS + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(DEPTH);
    end else begin
      if (push_ok)
        mem_q[tail_q] <= push_tag_i;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && push_i)
      assert (count_q != CW'(DEPTH))
        else $error("free list push while full");
  end
`endif
endmodule

// File: rtl/rename_map_stage.sv
// Rename stage: RAT lookup, free-tag allocation, one output register.
// Optional macro RENAME_ZERO_REG_EN hardwires arch reg 0 to tag 0.
module rename_map_stage
  import rename_pkg::*;
#(
  parameter int PHYS_REGS = 64,
  parameter int PTAG_W    = $clog2(PHYS_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ARCH_W-1:0] in_rs,
  input  logic [ARCH_W-1:0] in_rt,
  input  logic [ARCH_W-1:0] in_rd,
  input  logic              in_rd_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PTAG_W-1:0] out_ps,
  output logic [PTAG_W-1:0] out_pt,
  output logic [PTAG_W-1:0] out_pd,
  output logic [PTAG_W-1:0] out_old_pd,
  output logic              out_rd_we,
  input  logic              commit_valid,
  input  logic [PTAG_W-1:0] commit_tag,
  output logic [PTAG_W:0]   free_count
);
  logic [PTAG_W-1:0] rat_q [ARCH_REGS];

  logic              valid_q, valid_d;
  logic [PTAG_W-1:0] ps_q, ps_d;
  logic [PTAG_W-1:0] pt_q, pt_d;
  logic [PTAG_W-1:0] pd_q, pd_d;
  logic [PTAG_W-1:0] old_q, old_d;
  logic              we_q, we_d;

  logic              we_eff;
  logic [PTAG_W-1:0] src_a, src_b;
  logic              accept, pop;
  logic [PTAG_W-1:0] fl_head;
  logic [PTAG_W:0]   fl_count;

`ifdef RENAME_ZERO_REG_EN
  assign we_eff = in_rd_we & (in_rd != '0);
  assign src_a  = (in_rs == '0) ? '0 : rat_q[in_rs];
  assign src_b  = (in_rt == '0) ? '0 : rat_q[in_rt];
`else
  assign we_eff = in_rd_we;
  assign src_a  = rat_q[in_rs];
  assign src_b  = rat_q[in_rt];
`endif

  assign in_ready = (~valid_q | out_ready) & (fl_count != '0);
  assign accept   = in_valid & in_ready;
  assign pop      = accept & we_eff;

  rename_free_list #(
    .PHYS_REGS(PHYS_REGS),
    .PTAG_W   (PTAG_W)
  ) u_free_list (
    .clk       (clk),
    .reset     (reset),
    .push_i    (commit_valid),
    .push_tag_i(commit_tag),
    .pop_i     (pop),
    .head_o    (fl_head),
    .count_o   (fl_count)
  );

  always_comb begin
    valid_d = valid_q;
    ps_d    = ps_q;
    pt_d    = pt_q;
    pd_d    = pd_q;
    old_d   = old_q;
    we_d    = we_q;
    if (accept) begin
      valid_d = 1'b1;
      ps_d    = src_a;
      pt_d    = src_b;
      pd_d    = we_eff ? fl_head : '0;
      old_d   = we_eff ? rat_q[in_rd] : '0;
      we_d    = we_eff;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Sources above read rat_q before this write lands, so rd==rs
  // sees the old mapping and the next instruction sees the new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++)
        rat_q[i] <= PTAG_W'(i);
      valid_q <= 1'b0;
      ps_q    <= '0;
      pt_q    <= '0;
      pd_q    <= '0;
      old_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      if (pop)
        rat_q[in_rd] <= fl_head;
      valid_q <= valid_d;
      ps_q    <= ps_d;
      pt_q    <= pt_d;
      pd_q    <= pd_d;
      old_q   <= old_d;
      we_q    <= we_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_ps     = ps_q;
  assign out_pt     = pt_q;
  assign out_pd     = pd_q;
  assign out_old_pd = old_q;
  assign out_rd_we  = we_q;
  assign free_count = fl_count;
endmodule

// File: tb/tb_rename_map_stage.sv
// Self-checking bench for rename_map_stage against a queue/array model.
// Honours RENAME_ZERO_REG_EN when the design is built with it.
module tb_rename_map_stage;
  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_rs, in_rt, in_rd;
  logic       in_rd_we;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_ps, out_pt, out_pd, out_old_pd;
  logic       out_rd_we;
  logic       commit_valid;
  logic [5:0] commit_tag;
  logic [6:0] free_count;

  int checks = 0;
  int errors = 0;

  int m_rat [32];
  int m_fl [$];
  int pend [$];
  bit m_ov, m_we;
  int m_ps, m_pt, m_pd, m_old;

  rename_map_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_rd_we    (in_rd_we),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ps      (out_ps),
    .out_pt      (out_pt),
    .out_pd      (out_pd),
    .out_old_pd  (out_old_pd),
    .out_rd_we   (out_rd_we),
    .commit_valid(commit_valid),
    .commit_tag  (commit_tag),
    .free_count  (free_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int lookup(int r);
`ifdef RENAME_ZERO_REG_EN
    if (r == 0) return 0;
`endif
    return m_rat[r];
  endfunction

  function automatic bit exp_ready(bit ordy);
    return (!m_ov || ordy) && (m_fl.size() != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rat[i] = i;
    m_fl.delete();
    for (int t = 32; t < 64; t++) m_fl.push_back(t);
    pend.delete();
    m_ov = 0; m_we = 0;
    m_ps = 0; m_pt = 0; m_pd = 0; m_old = 0;
  endtask

  task automatic do_reset(bit v, bit cv);
    reset = 1; in_valid = v; commit_valid = cv;
    in_rs = 5; in_rt = 6; in_rd = 7; in_rd_we = 1;
    out_ready = 1; commit_tag = 6'd9;
    @(posedge clk);
    model_reset();
    #1;
    reset = 0; in_valid = 0; commit_valid = 0;
  endtask

  task automatic step(bit v, int rs, int rt, int rd, bit we,
                      bit ordy, bit cv, int ctag);
    bit rdy, acc, we_e, full;
    in_valid = v; in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_rd_we = we; out_ready = ordy;
    commit_valid = cv; commit_tag = 6'(ctag);
    @(posedge clk);
    rdy  = exp_ready(ordy);
    acc  = v && rdy;
    full = (m_fl.size() == 32);
    we_e = we;
`ifdef RENAME_ZERO_REG_EN
    if (rd == 0) we_e = 0;
`endif
    if (acc) begin
      m_ps = lookup(rs);
      m_pt = lookup(rt);
      if (we_e) begin
        m_pd  = m_fl.pop_front();
        m_old = m_rat[rd];
        m_rat[rd] = m_pd;
        pend.push_back(m_old);
      end else begin
        m_pd = 0; m_old = 0;
      end
      m_we = we_e;
      m_ov = 1;
    end else if (ordy) begin
      m_ov = 0;
    end
    if (cv && !full) m_fl.push_back(ctag);
    #1;
  endtask

  task automatic test_reset();
    do_reset(0, 0);
    checks++;
    if ({out_valid, out_ps, out_pt, out_pd, out_old_pd, out_rd_we} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b ps=%0d pt=%0d pd=%0d old=%0d we=%0b want all 0",
               out_valid, out_ps, out_pt, out_pd, out_old_pd, out_rd_we);
    end
    checks++;
    if (free_count !== 7'd32) begin
      errors++;
      $display("FAIL reset_free_count got %0d want 32", free_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
  endtask

  task automatic test_plan_basic();
    step(1, 1, 2, 5, 1, 1, 0, 0);
    checks++;
    if ({out_valid, out_ps, out_pt, out_pd, out_old_pd, out_rd_we} !==
        {1'b1, 6'd1, 6'd2, 6'd32, 6'd5, 1'b1}) begin
      errors++;
      $display("FAIL first_rename got v=%0b ps=%0d pt=%0d pd=%0d old=%0d want 1 1 2 32 5",
               out_valid, out_ps, out_pt, out_pd, out_old_pd);
    end
    step(1, 5, 5, 6, 1, 1, 0, 0);
    checks++;
    if ({out_ps, out_pt, out_pd, out_old_pd} !== {6'd32, 6'd32, 6'd33, 6'd6}) begin
      errors++;
      $display("FAIL back_to_back got ps=%0d pt=%0d pd=%0d old=%0d want 32 32 33 6",
               out_ps, out_pt, out_pd, out_old_pd);
    end
    step(1, 7, 3, 7, 1, 1, 0, 0);
    checks++;
    if ({out_ps, out_pt, out_pd, out_old_pd} !== {6'd7, 6'd3, 6'd34, 6'd7}) begin
      errors++;
      $display("FAIL rd_eq_rs got ps=%0d pt=%0d pd=%0d old=%0d want 7 3 34 7",
               out_ps, out_pt, out_pd, out_old_pd);
    end
    checks++;
    if (free_count !== 7'd29) begin
      errors++;
      $display("FAIL count_after_three got %0d want 29", free_count);
    end
    step(0, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid got %0b want 0", out_valid);
    end
  endtask

  task automatic test_exhaust();
    int guard = 0;
    while (m_fl.size() != 0 && guard < 64) begin
      step(1, $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(1, 31), 1, 1, 0, 0);
      guard++;
    end
    checks++;
    if (free_count !== 7'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL exhausted got count=%0d ready=%0b want 0 0", free_count, in_ready);
    end
    commit_valid = 1; commit_tag = 6'd5; in_valid = 0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL commit_same_cycle_ready got %0b want 0", in_ready);
    end
    step(0, 0, 0, 0, 0, 1, 1, 5);
    checks++;
    if (in_ready !== 1'b1 || free_count !== 7'd1) begin
      errors++;
      $display("FAIL after_commit got ready=%0b count=%0d want 1 1", in_ready, free_count);
    end
    step(1, 3, 4, 9, 1, 1, 0, 0);
    checks++;
    if (out_pd !== 6'd5 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reuse_commit got pd=%0d v=%0b want 5 1", out_pd, out_valid);
    end
  endtask

  task automatic test_stall();
    logic [25:0] snap;
    do_reset(0, 0);
    step(1, 1, 2, 3, 1, 0, 0, 0);
    snap = {out_ps, out_pt, out_pd, out_old_pd, out_rd_we, out_valid};
    step(1, 4, 5, 6, 1, 0, 0, 0);
    checks++;
    if ({out_ps, out_pt, out_pd, out_old_pd, out_rd_we, out_valid} !== snap ||
        out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold got %h want %h", {out_ps, out_pt, out_pd, out_old_pd,
               out_rd_we, out_valid}, snap);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready got %0b want 0", in_ready);
    end
    step(1, 4, 5, 6, 1, 1, 0, 0);
    checks++;
    if ({out_valid, out_ps, out_pt, out_pd, out_old_pd} !==
        {1'b1, 6'd4, 6'd5, 6'd33, 6'd6}) begin
      errors++;
      $display("FAIL stall_release got v=%0b ps=%0d pt=%0d pd=%0d old=%0d want 1 4 5 33 6",
               out_valid, out_ps, out_pt, out_pd, out_old_pd);
    end
  endtask

  task automatic test_zero_reg();
    do_reset(0, 0);
    step(1, 0, 0, 0, 1, 1, 0, 0);
`ifdef RENAME_ZERO_REG_EN
    checks++;
    if ({out_pd, out_rd_we, free_count} !== {6'd0, 1'b0, 7'd32}) begin
      errors++;
      $display("FAIL zero_rd got pd=%0d we=%0b count=%0d want 0 0 32",
               out_pd, out_rd_we, free_count);
    end
    step(1, 0, 4, 4, 1, 1, 0, 0);
    checks++;
    if (out_ps !== 6'd0 || out_pd !== 6'd32) begin
      errors++;
      $display("FAIL zero_src got ps=%0d pd=%0d want 0 32", out_ps, out_pd);
    end
`else
    checks++;
    if ({out_pd, out_old_pd, out_rd_we, free_count} !== {6'd32, 6'd0, 1'b1, 7'd31}) begin
      errors++;
      $display("FAIL zero_rd got pd=%0d old=%0d we=%0b count=%0d want 32 0 1 31",
               out_pd, out_old_pd, out_rd_we, free_count);
    end
    step(1, 0, 4, 4, 1, 1, 0, 0);
    checks++;
    if (out_ps !== 6'd32 || out_pd !== 6'd33) begin
      errors++;
      $display("FAIL zero_src got ps=%0d pd=%0d want 32 33", out_ps, out_pd);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset(0, 0);
    step(1, 1, 2, 5, 1, 1, 0, 0);
    step(1, 5, 2, 8, 1, 1, 0, 0);
    step(1, 5, 8, 5, 1, 1, 0, 0);
    do_reset(1, 1);
    checks++;
    if (free_count !== 7'd32 || out_valid !== 1'b0 || out_pd !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset got count=%0d v=%0b pd=%0d want 32 0 0",
               free_count, out_valid, out_pd);
    end
    step(1, 5, 8, 1, 1, 1, 0, 0);
    checks++;
    if (out_ps !== 6'd5 || out_pt !== 6'd8 || out_pd !== 6'd32) begin
      errors++;
      $display("FAIL mid_reset_rat got ps=%0d pt=%0d pd=%0d want 5 8 32",
               out_ps, out_pt, out_pd);
    end
  endtask

  task automatic test_random();
    bit cv, ordy;
    int ctag;
    do_reset(0, 0);
    for (int n = 0; n < 400; n++) begin
      ordy = ($urandom_range(0, 3) != 0);
      cv = 0; ctag = 0;
      if (pend.size() != 0 && m_fl.size() < 32 && $urandom_range(0, 1) == 1) begin
        cv = 1;
        ctag = pend.pop_front();
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 4) != 0, ordy, cv, ctag);
      checks++;
      if ({out_valid, out_ps, out_pt, out_pd, out_old_pd, out_rd_we, free_count} !==
          {m_ov, 6'(m_ps), 6'(m_pt), 6'(m_pd), 6'(m_old), m_we, 7'(m_fl.size())}) begin
        errors++;
        $display("FAIL random[%0d] got v=%0b ps=%0d pt=%0d pd=%0d old=%0d we=%0b cnt=%0d want v=%0b ps=%0d pt=%0d pd=%0d old=%0d we=%0b cnt=%0d",
                 n, out_valid, out_ps, out_pt, out_pd, out_old_pd, out_rd_we, free_count,
                 m_ov, m_ps, m_pt, m_pd, m_old, m_we, m_fl.size());
      end
      checks++;
      if (in_ready !== exp_ready(ordy)) begin
        errors++;
        $display("FAIL random_ready[%0d] got %0b want %0b", n, in_ready, exp_ready(ordy));
      end
    end
  endtask

  initial begin
    reset = 1; in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0;
    in_rd_we = 0; out_ready = 1; commit_valid = 0; commit_tag = 0;
    model_reset();
    test_reset();
    test_plan_basic();
    test_exhaust();
    test_stall();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
